// File: rtl/sram_arbiter_2m.sv
// Two-master round-robin arbiter in front of the SRAM wrapper; SRAM_ARB_TIMEOUT_EN adds a forced-completion watchdog.
// Latency: grant 1 cycle after valid in IDLE, one dead IDLE cycle between transactions.
// Backpressure: granted master stalls until s_ready; the losing master simply holds valid.
module sram_arbiter_2m #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        m0_valid,
  output logic        m0_ready,
  input  logic [3:0]  m0_wstrb,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  output logic        m1_ready,
  input  logic [3:0]  m1_wstrb,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  input  logic        s_ready,
  output logic [3:0]  s_wstrb,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  input  logic [31:0] s_rdata,
  output logic        arb_timeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   last_q, last_d;
  logic   sel1;
  logic   cur_valid;
  logic   done;
  logic   force_done;

  if ((TIMEOUT_CYCLES < 2) || (TIMEOUT_CYCLES > 255)) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 2..255");
  end

`ifdef SRAM_ARB_TIMEOUT_EN
  localparam logic [7:0] TO_FORCE = 8'(TIMEOUT_CYCLES);

  logic [7:0] cnt_q, cnt_d;
  logic       to_q, to_d;

  // Count saturates at TO_FORCE, which is the forced-completion cycle.
  assign force_done = (state_q != IDLE) && (cnt_q == TO_FORCE);

  always_comb begin
    cnt_d = cnt_q;
    to_d  = to_q;
    if (state_q == IDLE) begin
      cnt_d = 8'd0;
    end else if (force_done) begin
      to_d = 1'b1;
    end else if (!s_ready) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= 8'd0;
      to_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      to_q  <= to_d;
    end
  end

  assign arb_timeout = to_q;
`else
  assign force_done  = 1'b0;
  assign arb_timeout = 1'b0;
`endif

  assign sel1      = (state_q == BUSY1);
  assign cur_valid = sel1 ? m1_valid : m0_valid;
  assign m0_rdata  = force_done ? 32'hDEAD_BEEF : s_rdata;
  assign m1_rdata  = force_done ? 32'hDEAD_BEEF : s_rdata;

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    done     = 1'b0;
    s_valid  = 1'b0;
    s_wstrb  = 4'h0;
    s_addr   = 32'h0;
    s_wdata  = 32'h0;
    m0_ready = 1'b0;
    m1_ready = 1'b0;
    case (state_q)
      IDLE: begin
        // last_q names the previous winner, so a tie goes to the other master.
        if (m0_valid && m1_valid) begin
          state_d = last_q ? BUSY0 : BUSY1;
        end else if (m0_valid) begin
          state_d = BUSY0;
        end else if (m1_valid) begin
          state_d = BUSY1;
        end
      end
      BUSY0, BUSY1: begin
        s_wstrb = sel1 ? m1_wstrb : m0_wstrb;
        s_addr  = sel1 ? m1_addr  : m0_addr;
        s_wdata = sel1 ? m1_wdata : m0_wdata;
        if (force_done) begin
          done = 1'b1;
        end else begin
          s_valid = cur_valid;
          if (cur_valid && s_ready) begin
            done = 1'b1;
          end else if (!cur_valid) begin
            // Master withdrew mid-transaction: drop back without a completion.
            state_d = IDLE;
          end
        end
        if (done) begin
          state_d  = IDLE;
          last_d   = sel1;
          m0_ready = !sel1;
          m1_ready = sel1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_sram_arbiter_2m.sv
// Directed bench for sram_arbiter_2m with a one-cycle-ready SRAM wrapper model.
module tb_sram_arbiter_2m;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        m0_valid = 1'b0, m1_valid = 1'b0;
  logic        m0_ready, m1_ready;
  logic [3:0]  m0_wstrb = 4'h0, m1_wstrb = 4'h0;
  logic [31:0] m0_addr = 32'h0, m1_addr = 32'h0;
  logic [31:0] m0_wdata = 32'h0, m1_wdata = 32'h0;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_valid, s_ready;
  logic [3:0]  s_wstrb;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic        arb_timeout;

  logic        stall = 1'b0;
  logic        stray = 1'b0;
  logic        rdy_q;
  logic [31:0] rd_q;
  logic [31:0] mem [512];

  int checks = 0;
  int errors = 0;

  int          n_ev;
  int          sv_first;
  int          ev_m  [16];
  int          ev_t  [16];
  logic [31:0] ev_rd [16];
  logic [31:0] ev_wd [16];
  logic [3:0]  ev_ws [16];

  sram_arbiter_2m #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .resetn(resetn),
    .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_wstrb(m0_wstrb),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_wstrb(m1_wstrb),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_ready(s_ready), .s_wstrb(s_wstrb),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_rdata(s_rdata),
    .arb_timeout(arb_timeout)
  );

  always #5 clk = ~clk;

  // Wrapper model: accepts s_valid, answers with a one-cycle ready next cycle.
  assign s_ready = rdy_q | stray;
  assign s_rdata = rd_q;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdy_q   <= 1'b0;
      rd_q    <= 32'h0;
      mem[4]  <= 32'h1234_5678;
    end else if (s_valid && !rdy_q && !stall) begin
      rdy_q <= 1'b1;
      rd_q  <= mem[s_addr[10:2]];
      for (int b = 0; b < 4; b++) begin
        if (s_wstrb[b]) mem[s_addr[10:2]][8*b +: 8] <= s_wdata[8*b +: 8];
      end
    end else begin
      rdy_q <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  // Runs a bounded number of cycles, logging completions; masters drop valid after their ready unless hold.
  task automatic run(input int cycles, input bit hold);
    bit d0, d1;
    d0 = 1'b0;
    d1 = 1'b0;
    n_ev = 0;
    sv_first = -1;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (d0) m0_valid = 1'b0;
      if (d1) m1_valid = 1'b0;
      d0 = 1'b0;
      d1 = 1'b0;
      #1;
      if (s_valid && sv_first < 0) sv_first = i;
      if ((m0_ready || m1_ready) && n_ev < 16) begin
        ev_m[n_ev]  = m1_ready ? 1 : 0;
        ev_t[n_ev]  = i;
        ev_rd[n_ev] = m1_ready ? m1_rdata : m0_rdata;
        ev_wd[n_ev] = s_wdata;
        ev_ws[n_ev] = s_wstrb;
        n_ev++;
        d0 = m0_ready && !hold;
        d1 = m1_ready && !hold;
      end
    end
  endtask

  initial begin
    // Outputs during reset
    repeat (2) @(posedge clk);
    #1;
    chk("rst_s_valid", 32'(s_valid), 32'd0);
    chk("rst_m0_ready", 32'(m0_ready), 32'd0);
    chk("rst_m1_ready", 32'(m1_ready), 32'd0);
    chk("rst_s_addr", s_addr, 32'h0);
    chk("rst_timeout", 32'(arb_timeout), 32'd0);
    resetn = 1'b1;

    // Single uncontested read
    tick();
    m0_valid = 1'b1; m0_wstrb = 4'h0; m0_addr = 32'h10;
    #1;
    chk("rd_sv_before", 32'(s_valid), 32'd0);
    run(6, 1'b0);
    chk("rd_nev", n_ev, 1);
    chk("rd_sv_first", sv_first, 0);
    chk("rd_master", ev_m[0], 0);
    chk("rd_cycle", ev_t[0], 1);
    chk("rd_data", ev_rd[0], 32'h1234_5678);

    // Simultaneous requests straight out of reset: m0 wins first
    do_reset();
    m0_valid = 1'b1; m0_wstrb = 4'hF; m0_addr = 32'h20; m0_wdata = 32'hA5A5_A5A5;
    m1_valid = 1'b1; m1_wstrb = 4'h0; m1_addr = 32'h20;
    run(8, 1'b0);
    chk("tie_nev", n_ev, 2);
    chk("tie_first", ev_m[0], 0);
    chk("tie_first_t", ev_t[0], 1);
    chk("tie_second", ev_m[1], 1);
    chk("tie_second_t", ev_t[1], 4);
    chk("tie_rdback", ev_rd[1], 32'hA5A5_A5A5);

    // Sustained contention alternates with one idle cycle between grants
    m0_valid = 1'b1; m0_wstrb = 4'h0; m0_addr = 32'h10;
    m1_valid = 1'b1; m1_wstrb = 4'h0; m1_addr = 32'h20;
    run(18, 1'b1);
    m0_valid = 1'b0;
    m1_valid = 1'b0;
    chk("cont_nev", n_ev, 6);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("cont_m%0d", k), ev_m[k], k % 2);
      chk($sformatf("cont_t%0d", k), ev_t[k], 1 + 3 * k);
    end
    tick();

    // Abort: m0 withdraws inside BUSY0, then a stray ready lands in IDLE
    stall = 1'b1;
    m0_valid = 1'b1; m0_addr = 32'h10;
    tick();
    chk("ab_sv_busy", 32'(s_valid), 32'd1);
    tick();
    m0_valid = 1'b0;
    #1;
    chk("ab_no_ready", 32'(m0_ready), 32'd0);
    chk("ab_sv_drop", 32'(s_valid), 32'd0);
    tick();
    stray = 1'b1;
    #1;
    chk("ab_stray_m0", 32'(m0_ready), 32'd0);
    chk("ab_stray_m1", 32'(m1_ready), 32'd0);
    chk("ab_stray_sv", 32'(s_valid), 32'd0);
    tick();
    stray = 1'b0;
    stall = 1'b0;
    // m1 was the last completed winner, so a tie must still go to m0
    m0_valid = 1'b1; m0_addr = 32'h10;
    m1_valid = 1'b1; m1_addr = 32'h10;
    run(8, 1'b0);
    chk("ab_tie_nev", n_ev, 2);
    chk("ab_tie_first", ev_m[0], 0);
    chk("ab_tie_first_t", ev_t[0], 1);

    // Byte write from m1, then read-back from m0
    m1_valid = 1'b1; m1_wstrb = 4'h2; m1_addr = 32'h20; m1_wdata = 32'h0000_BB00;
    run(5, 1'b0);
    chk("bw_nev", n_ev, 1);
    chk("bw_master", ev_m[0], 1);
    chk("bw_wstrb", 32'(ev_ws[0]), 32'h2);
    chk("bw_wdata", ev_wd[0], 32'h0000_BB00);
    m1_wstrb = 4'h0;
    m0_valid = 1'b1; m0_wstrb = 4'h0; m0_addr = 32'h20;
    run(5, 1'b0);
    chk("bw_rdback", ev_rd[0], 32'hA5A5_BBA5);

    // Asynchronous reset in BUSY1 clears outputs before the next edge
    m1_valid = 1'b1; m1_addr = 32'h20; m1_wdata = 32'h1111_2222;
    tick();
    chk("ar_sv_busy", 32'(s_valid), 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    chk("ar_sv", 32'(s_valid), 32'd0);
    chk("ar_m1_ready", 32'(m1_ready), 32'd0);
    chk("ar_s_addr", s_addr, 32'h0);
    tick();
    m1_valid = 1'b0;
    resetn = 1'b1;
    tick();

    // Wrapper never answers
    stall = 1'b1;
    m0_valid = 1'b1; m0_addr = 32'h10;
    run(24, 1'b0);
`ifdef SRAM_ARB_TIMEOUT_EN
    chk("to_nev", n_ev, 1);
    chk("to_cycle", ev_t[0], 16);
    chk("to_rdata", ev_rd[0], 32'hDEAD_BEEF);
    chk("to_flag", 32'(arb_timeout), 32'd1);
    repeat (4) tick();
    chk("to_sticky", 32'(arb_timeout), 32'd1);
`else
    chk("stall_nev", n_ev, 0);
    chk("stall_flag", 32'(arb_timeout), 32'd0);
    chk("stall_sv", 32'(s_valid), 32'd1);
`endif
    m0_valid = 1'b0;
    tick();
    stall = 1'b0;
    do_reset();
    chk("end_flag", 32'(arb_timeout), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
